stream_muxer: RTL and testbench
===============================

// Module: stream_muxer
// PURPOSE
//  - N-channel, WIDTH-bit registered stream multiplexer. It generalises the 2:1/4:1 bit muxers:
//    the select is generated internally by a round-robin arbiter, not driven by an input.
//  - Each input channel has a valid/ready handshake. Output is one registered valid/ready stream.
//  - Sits between several producers (UART RX, counters, pattern generators) and a single consumer.
// PARAMETERS
//  - N_CH   4   number of input channels; legal range 2..16
//  - WIDTH  8   data width in bits, per channel and at the output
//  - SEL_W  $clog2(N_CH)   localparam; width of the channel index
// PORTS
//  - clk        in   1             single clock, rising edge
//  - rst_n      in   1             synchronous reset, active-low
//  - in_data    in   N_CH x WIDTH  unpacked array [N_CH][WIDTH] of channel data
//  - in_valid   in   N_CH          channel c presents a beat
//  - in_ready   out  N_CH          beat on channel c is accepted this cycle
//  - out_data   out  WIDTH         registered output data
//  - out_valid  out  1             out_data holds a beat
//  - out_ready  in   1             consumer accepts the beat
//  - out_sel    out  SEL_W         source channel of the beat in out_data
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge clk): out_valid=0, out_data=0, out_sel=0, priority pointer ptr=N_CH-1.
//    Reset wins over every other event in the same cycle. A beat held at reset is dropped.
//  - Transfer rule: a beat transfers when valid && ready at the same posedge. Data is stable while valid && !ready.
//  - load = !out_valid || out_ready. The output stage accepts a new beat when it is empty or being drained.
//  - Arbitration is combinational each cycle. The grant g is the first c with in_valid[c]=1, scanning
//    ptr+1, ptr+2, ... modulo N_CH (wrap-around N_CH-1 -> 0).
//  - in_ready[c] = load && any_valid && (c==g). At most one in_ready bit is high. in_ready has no dependence
//    on in_valid of other channels beyond the grant.
//  - On a transfer from g: out_data<=in_data[g], out_sel<=g, out_valid<=1, ptr<=g.
//  - If out_ready=1 and no input transfers: out_valid<=0. If out_valid=1 and out_ready=0: all registers hold.
//  - Latency is 1 cycle from input transfer to out_valid. Full throughput is 1 beat/cycle with out_ready held at 1.
//  - Simultaneous drain and fill: out_valid stays 1 and the new beat replaces the old one.
//  - Fairness: with all channels valid, grants rotate 0,1,...,N_CH-1,0,... Each channel waits at most N_CH-1 beats.
//  - No input valid: ptr holds. It is never advanced without a transfer.
// CONFIGURATION
//  - Macro STREAM_MUXER_PKT_LOCK_EN.
//  - Defined:
//    - Adds ports in_last (in, N_CH) and out_last (out, 1). out_last is registered alongside out_data and resets to 0.
//    - A transfer from g with in_last[g]=0 sets lock=1 and lock_ch=g. While lock=1 the grant is forced to
//      lock_ch, whether or not lock_ch is valid. Other channels see in_ready=0.
//    - A transfer with in_last=1 clears lock. lock resets to 0.
//    - Single-beat packets (last=1) behave exactly as in unlocked mode.
//  - Undefined: no last ports and no lock state. Every beat is arbitrated independently.
// STRUCTURE
//  - Package muxer_pkg:
//    - typedef logic [WIDTH-1:0] data_t, with default WIDTH from pkg constant MUX_WIDTH_DEF=8
//    - constant MUX_NCH_DEF=4
//    - function rr_next(req, ptr) returning the first requester after ptr
//  - Sub-module rr_arbiter #(N_CH):
//    - ports clk, rst_n, req[N_CH], advance, grant_idx[SEL_W], grant_vld
//    - owns ptr and, under the macro, lock/lock_ch
//  - stream_muxer: the output register stage plus in_ready decode.
// TESTING
//  - Reset: drive rst_n=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0 after the edge.
//    First grant after release is channel 0.
//  - Round-robin: all 4 channels valid, data = 8'hA0+c, out_ready=1 -> out_data sequence A0,A1,A2,A3,A0
//    on consecutive cycles; out_sel 0,1,2,3,0.
//  - Backpressure: out_valid=1 with out_data=A1, out_ready=0 for 3 cycles -> out_data, out_sel, out_valid hold.
//    in_ready=0. On release, A1 drains and A2 loads the same cycle.
//  - Sparse/wrap: only ch3 valid (8'h33), then only ch0 valid (8'h00) -> 33 then 00 back-to-back. ptr wraps 3 -> 0.
//  - Reset mid-stream: rst_n=0 while out_valid=1 (out_data=8'h5A) -> next cycle out_valid=0, out_data=0.
//    Grant order restarts at ch0.
//  - PKT_LOCK_EN: ch1 sends 3 beats (last=0,0,1) while ch0 and ch2 stay valid ->
//    out_sel=1,1,1 contiguously, then 2, then 0. A 1-cycle ch1 valid gap inside the packet leaves out_sel unchanged.

Source files
------------

// File: rtl/muxer_pkg.sv
// Shared constants, types and the round-robin search helper for stream_muxer.
// Only the lock feature (STREAM_MUXER_PKT_LOCK_EN) uses arb_state_e.
package muxer_pkg;

  localparam int MUX_WIDTH_DEF = 8;
  localparam int MUX_NCH_DEF   = 4;
  localparam int MUX_NCH_MAX   = 16;

  typedef logic [MUX_WIDTH_DEF-1:0] data_t;

  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // First requester strictly after ptr, wrapping modulo n_ch.
  // Returns ptr when nothing requests.
  function automatic logic [3:0] rr_next(input logic [15:0] req,
                                         input logic [3:0]  ptr,
                                         input int unsigned n_ch = MUX_NCH_DEF);
    logic [3:0] idx;
    rr_next = ptr;
    // Walk from farthest to nearest so the nearest requester wins.
    for (int i = MUX_NCH_MAX; i >= 1; i--) begin
      if (i <= n_ch) begin
        idx = 4'((int'(ptr) + i) % n_ch);
        if (req[idx]) rr_next = idx;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: owns the priority pointer and, with STREAM_MUXER_PKT_LOCK_EN,
// the packet lock that pins the grant to one channel until its last beat.
module rr_arbiter
  import muxer_pkg::*;
#(
  parameter  int N_CH  = MUX_NCH_DEF,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  req,
  input  logic             advance,
`ifdef STREAM_MUXER_PKT_LOCK_EN
  input  logic             last,
`endif
  output logic [SEL_W-1:0] grant_idx,
  output logic             grant_vld
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rr_idx;
  logic             any_req;

  assign rr_idx  = SEL_W'(rr_next(16'(req), 4'(ptr), N_CH));
  assign any_req = |req;

  // ptr only moves on an accepted beat, never on an idle cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)       ptr <= SEL_W'(N_CH - 1);
    else if (advance) ptr <= grant_idx;
  end

`ifdef STREAM_MUXER_PKT_LOCK_EN
  arb_state_e       state, state_nxt;
  logic [SEL_W-1:0] lock_ch, lock_ch_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ARB_FREE;
      lock_ch <= '0;
    end else begin
      state   <= state_nxt;
      lock_ch <= lock_ch_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    lock_ch_nxt = lock_ch;
    grant_idx   = rr_idx;
    grant_vld   = any_req;
    // A locked channel keeps the grant even while it idles mid-packet.
    if (state == ARB_LOCKED) begin
      grant_idx = lock_ch;
      grant_vld = req[lock_ch];
    end
    if (advance) begin
      if (last) begin
        state_nxt = ARB_FREE;
      end else begin
        state_nxt   = ARB_LOCKED;
        lock_ch_nxt = grant_idx;
      end
    end
  end
`else
  assign grant_idx = rr_idx;
  assign grant_vld = any_req;
`endif

endmodule

// File: rtl/stream_muxer.sv
// N-channel registered stream mux with an internal round-robin select.
// Optional packet lock via STREAM_MUXER_PKT_LOCK_EN (adds in_last/out_last).
module stream_muxer
  import muxer_pkg::*;
#(
  parameter  int N_CH  = MUX_NCH_DEF,
  parameter  int WIDTH = MUX_WIDTH_DEF,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data [N_CH],
  input  logic [N_CH-1:0]  in_valid,
  output logic [N_CH-1:0]  in_ready,
`ifdef STREAM_MUXER_PKT_LOCK_EN
  input  logic [N_CH-1:0]  in_last,
  output logic             out_last,
`endif
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] out_sel
);

  logic             load;
  logic             xfer;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_vld;

  assign load = !out_valid || out_ready;
  // Gating with rst_n keeps in_ready low while in reset so no beat is lost upstream.
  assign xfer = rst_n && load && grant_vld;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (in_valid),
    .advance   (xfer),
`ifdef STREAM_MUXER_PKT_LOCK_EN
    .last      (in_last[grant_idx]),
`endif
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  for (genvar c = 0; c < N_CH; c++) begin : g_rdy
    assign in_ready[c] = xfer && (grant_idx == SEL_W'(c));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant_idx];
      out_sel   <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef STREAM_MUXER_PKT_LOCK_EN
  always_ff @(posedge clk) begin
    if (!rst_n)    out_last <= 1'b0;
    else if (xfer) out_last <= in_last[grant_idx];
  end
`endif

endmodule

// File: tb/tb_stream_muxer.sv
// Scoreboard bench for stream_muxer: directed vectors push expected beats,
// a negedge monitor pops and compares on every output handshake.
module tb_stream_muxer;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data [4];
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_sel;
`ifdef STREAM_MUXER_PKT_LOCK_EN
  logic [3:0] in_last;
  logic       out_last;
`endif

  int    errors = 0;
  int    checks = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  stream_muxer #(.N_CH(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef STREAM_MUXER_PKT_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] s, input logic [7:0] d);
    beat_t b;
    b.sel  = s;
    b.data = d;
    exp_q.push_back(b);
  endtask

  task automatic std_data();
    for (int c = 0; c < 4; c++) in_data[c] = 8'hA0 + 8'(c);
  endtask

  // Monitor: every accepted output beat must match the head of the queue.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_beat: got sel=%0d data=%0h expected none", out_sel, out_data);
      end else begin
        e = exp_q.pop_front();
        check("beat_sel", 32'(out_sel), 32'(e.sel));
        check("beat_data", 32'(out_data), 32'(e.data));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 4'b1111;
    std_data();
`ifdef STREAM_MUXER_PKT_LOCK_EN
    in_last   = 4'b1111;
`endif

    // Reset held two edges with every channel valid.
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_sel", 32'(out_sel), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    tick();
    check("rst2_out_valid", 32'(out_valid), 0);
    check("rst2_in_ready", 32'(in_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_grant_ch0", 32'(in_ready), 32'h1);

    // Round-robin at full throughput.
    push(0, 8'hA0); push(1, 8'hA1); push(2, 8'hA2); push(3, 8'hA3); push(0, 8'hA0);
    repeat (5) tick();
    in_valid = 4'b0000;
    tick();
    check("rr_drained", 32'(out_valid), 0);

    // Backpressure: A1 must hold for three cycles.
    push(1, 8'hA1); push(2, 8'hA2);
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_out_data", 32'(out_data), 32'hA1);
      check("bp_out_sel", 32'(out_sel), 1);
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_in_ready", 32'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(in_ready), 32'h4);
    tick();
    check("bp_refill_data", 32'(out_data), 32'hA2);
    check("bp_refill_valid", 32'(out_valid), 1);
    in_valid = 4'b0000;
    tick();

    // Sparse channels: ch3 then ch0 back-to-back across the wrap.
    push(3, 8'h33); push(0, 8'h00);
    in_data[3] = 8'h33;
    in_valid   = 4'b1000;
    tick();
    in_data[0] = 8'h00;
    in_valid   = 4'b0001;
    tick();
    check("wrap_sel", 32'(out_sel), 0);
    check("wrap_valid", 32'(out_valid), 1);
    in_valid = 4'b0000;
    tick();

    // Reset while a stalled beat sits in the output register.
    in_data[2] = 8'h5A;
    in_valid   = 4'b0100;
    out_ready  = 1'b0;
    tick();
    check("mid_pre_data", 32'(out_data), 32'h5A);
    check("mid_pre_valid", 32'(out_valid), 1);
    rst_n    = 1'b0;
    in_valid = 4'b0000;
    tick();
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_data", 32'(out_data), 0);
    check("mid_rst_sel", 32'(out_sel), 0);
    rst_n     = 1'b1;
    std_data();
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    push(0, 8'hA0); push(1, 8'hA1);
    @(negedge clk);
    check("mid_restart_ch0", 32'(in_ready), 32'h1);
    tick();
    tick();
    in_valid = 4'b0000;
    tick();

`ifdef STREAM_MUXER_PKT_LOCK_EN
    // Move ptr to 0, then lock onto a 3-beat ch1 packet with a gap inside.
    push(0, 8'hA0);
    in_valid = 4'b0001;
    tick();
    push(1, 8'h11); push(1, 8'h12); push(1, 8'h13); push(2, 8'h22); push(0, 8'h0F);
    in_data[0] = 8'h0F;
    in_data[1] = 8'h11;
    in_data[2] = 8'h22;
    in_last    = 4'b1101;
    in_valid   = 4'b0111;
    tick();
    check("lock_last0", 32'(out_last), 0);
    in_valid = 4'b0101;
    @(negedge clk);
    check("lock_gap_ready", 32'(in_ready), 0);
    tick();
    check("lock_gap_sel", 32'(out_sel), 1);
    check("lock_gap_valid", 32'(out_valid), 0);
    in_valid   = 4'b0111;
    in_data[1] = 8'h12;
    tick();
    in_data[1] = 8'h13;
    in_last    = 4'b1111;
    tick();
    check("lock_last1", 32'(out_last), 1);
    in_valid = 4'b0101;
    tick();
    tick();
    in_valid = 4'b0000;
    tick();
`endif

    for (int w = 0; w < 20 && exp_q.size() != 0; w++) tick();
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
